hilo_muldiv_seq: RTL and testbench
==================================

// Module: hilo_muldiv_seq
// PURPOSE
//  Sequencer for the HI/LO multiply/divide resource. Accepts MULTU/DIVU from decode,
//  runs an iterative radix-2 shift-add multiply or restoring divide over WIDTH cycles,
//  writes HI/LO on completion, and stalls the pipeline for MFHI/MFLO while an op is in flight.
//  Sits beside the ALU and is driven by the control unit's we_hilo and hilo_sel decode.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  start         in   1      issue op this cycle (we_hilo from decode)
//  op_div        in   1      0 = MULTU, 1 = DIVU; sampled with start
//  src_a         in   WIDTH  multiplicand / dividend, sampled with start
//  src_b         in   WIDTH  multiplier / divisor, sampled with start
//  rd_req        in   1      MFHI/MFLO in decode wants HI/LO this cycle
//  busy          out  1      op in flight (MUL or DIV state)
//  stall         out  1      rd_req & busy; also high for start while busy
//  done          out  1      one-cycle pulse: HI/LO updated
//  div_by_zero   out  1      sticky flag for last DIVU with src_b==0
//  hi            out  WIDTH  HI register
//  lo            out  WIDTH  LO register
// BEHAVIOUR
//  Reset (rst_n=0, any time incl. mid-op): state=IDLE; hi=lo=0; busy=stall=done=0;
//   div_by_zero=0; iteration counter and working regs cleared; in-flight op discarded.
//  States: IDLE, MUL, DIV, DONE (2-bit encoding).
//  IDLE: start&~op_div -> MUL; start&op_div&src_b!=0 -> DIV; start&op_div&src_b==0 -> DONE.
//   Operands latched on the start edge; counter loaded with WIDTH-1; div_by_zero cleared.
//  MUL: per cycle, if multiplier LSB then acc_hi += multiplicand (WIDTH+1-bit sum,
//   carry kept); {carry,acc} shifts right 1. Unsigned only.
//  DIV: per cycle, shift {rem,quo} left 1; trial = rem - divisor (WIDTH+1 bits);
//   if trial non-negative, rem=trial and quo LSB=1, else restore. Unsigned only.
//  MUL/DIV: counter decrements; at counter==0 -> DONE, and HI/LO written on that edge:
//   MULTU: hi=product[2W-1:W], lo=product[W-1:0]; DIVU: hi=remainder, lo=quotient.
//  Divide-by-zero: goes IDLE->DONE directly; on that edge hi=src_a, lo={WIDTH{1}},
//   div_by_zero=1 (held until next accepted start or reset).
//  DONE: done=1 for exactly this cycle; busy=0; -> IDLE unconditionally.
//   A start in DONE is NOT accepted (stall=0, ignored); decode must reissue.
//  Latency: start at cycle N -> done at N+WIDTH+1 (33 for WIDTH=32); div-by-zero: N+1.
//  busy=1 only in MUL/DIV. stall = busy & (rd_req | start). start while busy ignored, no
//   operand relatch. HI/LO stable outside the write edge; MFHI/MFLO in DONE reads new values.
//  Simultaneous rd_req and completion edge: stall drops in DONE, read sees updated HI/LO.
// TESTING
//  1 MULTU 0xFFFFFFFF*0xFFFFFFFF: done at start+33; hi=0xFFFFFFFE, lo=0x00000001.
//  2 DIVU 100/7: done at start+33; lo=14, hi=2; div_by_zero=0.
//  3 DIVU 0x1234/0: done at start+1; hi=0x00001234, lo=0xFFFFFFFF, div_by_zero=1.
//  4 MULTU 3*5 with 2nd start (7*7) at +5 and rd_req held: stall=1 in cycles +1..+32,
//    hi=0, lo=15 at done; 2nd op ignored.
//  5 rst_n low at start+10 of MULTU 6*7: busy,hi,lo=0 immediately; no done afterward.
//  6 Back-to-back: start in DONE ignored; start next cycle (IDLE) -> done 33 cycles later.

Source files
------------

// File: rtl/hilo_muldiv_seq.sv
// HI/LO multiply/divide sequencer: iterative radix-2 MULTU and restoring DIVU,
// with pipeline stall generation for MFHI/MFLO while an operation is in flight.
module hilo_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  // upper: partial product high half / remainder; lower: multiplier / quotient
  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH-1:0] operand;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_upper_nx;
  logic [WIDTH-1:0] mul_lower_nx;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] div_upper_nx;
  logic [WIDTH-1:0] div_lower_nx;

  always_comb begin
    mul_sum = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
    {mul_upper_nx, mul_lower_nx} = {mul_sum, lower[WIDTH-1:1]};
  end

  // Remainder before the shift is below the divisor, so the WIDTH+1-bit
  // difference's top bit is a valid sign even when rem_sh exceeds WIDTH bits.
  always_comb begin
    rem_sh = {upper, lower[WIDTH-1]};
    trial  = rem_sh - {1'b0, operand};
    if (!trial[WIDTH]) begin
      div_upper_nx = trial[WIDTH-1:0];
      div_lower_nx = {lower[WIDTH-2:0], 1'b1};
    end else begin
      div_upper_nx = rem_sh[WIDTH-1:0];
      div_lower_nx = {lower[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      upper       <= '0;
      lower       <= '0;
      operand     <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            cnt         <= CW'(WIDTH - 1);
            if (op_div && (src_b == '0)) begin
              hi          <= src_a;
              lo          <= '1;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else if (op_div) begin
              upper   <= '0;
              lower   <= src_a;
              operand <= src_b;
              state   <= S_DIV;
            end else begin
              upper   <= '0;
              lower   <= src_b;
              operand <= src_a;
              state   <= S_MUL;
            end
          end
        end
        S_MUL: begin
          upper <= mul_upper_nx;
          lower <= mul_lower_nx;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            hi    <= mul_upper_nx;
            lo    <= mul_lower_nx;
            state <= S_DONE;
          end
        end
        S_DIV: begin
          upper <= div_upper_nx;
          lower <= div_lower_nx;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            hi    <= div_upper_nx;
            lo    <= div_lower_nx;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state == S_MUL) || (state == S_DIV);
  assign stall = busy & (rd_req | start);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Bench for hilo_muldiv_seq: cycle-level arithmetic model checked every cycle,
// plus directed scenarios with hand-computed results and latencies.
module tb_hilo_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_div = 1'b0;
  logic         rd_req = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, stall, done, div_by_zero;
  logic [W-1:0] hi, lo;

  hilo_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div),
    .src_a(src_a), .src_b(src_b), .rd_req(rd_req),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model: an accepted op keeps the unit busy for W cycles, then results appear.
  int           remain = 0;
  bit           m_done = 1'b0;
  bit           m_dbz = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic [2*W-1:0] prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain = 0; m_done = 1'b0; m_dbz = 1'b0; m_hi = '0; m_lo = '0;
    end else if (remain > 0) begin
      remain = remain - 1;
      if (remain == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      m_dbz = 1'b0;
      if (op_div && src_b == 0) begin
        m_hi = src_a; m_lo = '1; m_dbz = 1'b1; m_done = 1'b1;
      end else if (op_div) begin
        p_hi = src_a % src_b; p_lo = src_a / src_b; remain = W;
      end else begin
        prod = {{W{1'b0}}, src_a} * {{W{1'b0}}, src_b};
        p_hi = prod[2*W-1:W]; p_lo = prod[W-1:0]; remain = W;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", busy, remain > 0);
      chk("done", done, m_done);
      chk("stall", stall, (remain > 0) && (rd_req || start));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("div_by_zero", div_by_zero, m_dbz);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic div);
    src_a = a; src_b = b; op_div = div; start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle; lat counts cycles since start.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) return;
      next_cycle();
      lat++;
    end
    checks++; errors++;
    $display("FAIL done_timeout: got no done expected done within 100 cycles");
  endtask

  int lat;
  int ndone;

  initial begin
    #1 check_en = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dbz", div_by_zero, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // 1: MULTU max*max
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(1, lat);
    chk("t1_lat", lat, 33);
    chk("t1_hi", hi, 32'hFFFF_FFFE);
    chk("t1_lo", lo, 32'h0000_0001);
    next_cycle();

    // 2: DIVU 100/7
    issue(32'd100, 32'd7, 1'b1);
    wait_done(1, lat);
    chk("t2_lat", lat, 33);
    chk("t2_lo", lo, 14);
    chk("t2_hi", hi, 2);
    chk("t2_dbz", div_by_zero, 0);
    next_cycle();

    // 3: DIVU by zero
    issue(32'h1234, 32'h0, 1'b1);
    wait_done(1, lat);
    chk("t3_lat", lat, 1);
    chk("t3_hi", hi, 32'h0000_1234);
    chk("t3_lo", lo, 32'hFFFF_FFFF);
    chk("t3_dbz", div_by_zero, 1);
    next_cycle();

    // 4: MULTU 3*5, second start ignored while busy, rd_req held
    rd_req = 1'b1;
    issue(32'd3, 32'd5, 1'b0);
    repeat (4) next_cycle();
    src_a = 32'd7; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    chk("t4_stall_start", stall, 1);
    next_cycle();
    start = 1'b0;
    wait_done(6, lat);
    chk("t4_lat", lat, 33);
    chk("t4_stall_done", stall, 0);
    chk("t4_hi", hi, 0);
    chk("t4_lo", lo, 15);
    next_cycle();
    rd_req = 1'b0;

    // 5: reset mid-op
    issue(32'd6, 32'd7, 1'b0);
    repeat (9) next_cycle();
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_hi", hi, 0);
    chk("t5_lo", lo, 0);
    next_cycle();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
      next_cycle();
    end
    chk("t5_no_done", ndone, 0);

    // 6: start in DONE ignored, start in following IDLE accepted
    issue(32'd9, 32'd9, 1'b0);
    wait_done(1, lat);
    chk("t6a_lo", lo, 81);
    #1;
    src_a = 32'd50; src_b = 32'd5; op_div = 1'b1; start = 1'b1;
    next_cycle();
    src_a = 32'h0001_0000; src_b = 32'h0001_0000; op_div = 1'b0;
    @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    next_cycle();
    start = 1'b0;
    wait_done(1, lat);
    chk("t6_lat", lat, 33);
    chk("t6_hi", hi, 1);
    chk("t6_lo", lo, 0);
    next_cycle();

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
